// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: bundles the SPI pins, the SPI mode selects and the
// transmit/receive handshakes of one spi_slave_sync instance.
// The slave modport is the block's own view of the bundle. The master modport
// is the view of whatever drives the pins and consumes the words.
interface spi_slave_sync_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  // SPI mode, only looked at while the frame is idle
  logic                  cpol;
  logic                  cpha;

  // Transmit handshake
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Receive handshake
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  // Status
  logic                  rx_overrun;
  logic                  tx_underrun;
  logic                  busy;

  // Asynchronous SPI pins
  logic                  sclk;
  logic                  csb;
  logic                  din;
  logic                  dout;

  modport slave (
    input  cpol, cpha,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready,
    output rx_overrun, tx_underrun, busy,
    input  sclk, csb, din,
    output dout
  );

  modport master (
    output cpol, cpha,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready,
    input  rx_overrun, tx_underrun, busy,
    output sclk, csb, din,
    input  dout
  );

endinterface

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave that oversamples sclk/csb/din with the system
// clock. The block supports all four SPI modes, a configurable word width and
// a configurable bit order. It has a one-word transmit holding register and a
// one-word receive output register, and it pulses single-cycle error flags on
// receive overrun and on transmit underrun.
// sclk must run at no more than a quarter of the clk rate.
module spi_slave_sync #(
  parameter int unsigned DATA_WIDTH  = 16,   // 2..64
  parameter int unsigned SYNC_STAGES = 2,    // 2..4
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic            clk,
  input  logic            resetb,
  spi_slave_sync_if.slave bus
);

  localparam int unsigned     CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam int unsigned     FIRST_BIT = MSB_FIRST ? DATA_WIDTH - 1 : 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Synchronisers and previous-sample registers for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] csb_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_prev_q;
  logic                   csb_prev_q;
  logic                   sclk_s;
  logic                   csb_s;
  logic                   din_s;
  logic                   csb_fall;

  // Frame control
  state_e                 state_q;
  state_e                 state_d;
  logic                   frame_start;
  logic                   in_frame;
  logic                   cpol_q;
  logic                   cpha_q;

  // SPI clock edges, decoded for the latched mode
  logic                   lead_edge;
  logic                   trail_edge;
  logic                   sample_edge;
  logic                   shift_edge;
  logic                   word_start;
  logic                   word_done;
  logic                   hold_edge;
  logic                   reload_edge;
  logic                   load;

  // Bit position within the current word
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   first_word_q;

  // Receive path
  logic [DATA_WIDTH-1:0]  rx_shift_q;
  logic [DATA_WIDTH-1:0]  rx_next;
  logic [DATA_WIDTH-1:0]  rx_data_q;
  logic                   rx_valid_q;
  logic                   rx_overrun_q;
  logic                   rx_handshake;

  // Transmit path
  logic [DATA_WIDTH-1:0]  hold_q;
  logic                   hold_full_q;
  logic [DATA_WIDTH-1:0]  tx_shift_q;
  logic [DATA_WIDTH-1:0]  tx_shifted;
  logic [DATA_WIDTH-1:0]  load_word;
  logic                   tx_handshake;
  logic                   tx_underrun_q;

  // ---------------------------------------------------------------------------
  // Pin synchronisation
  // ---------------------------------------------------------------------------

  // Bring the asynchronous pins into the clk domain and keep one extra sample
  // for edge detection.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register reads the values from before the clock edge, no matter how the
  // statements are ordered.
  // NOTE: the csb chain resets to 0, not to its idle level. If csb is held low
  // through reset, the block then sees no falling edge. A frame that was cut
  // by reset can only restart after csb goes high and then falls again.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_sync_q <= '0;
      csb_sync_q  <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], bus.csb};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], bus.din};
      sclk_prev_q <= sclk_s;
      csb_prev_q  <= csb_s;
    end
  end

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign csb_fall = csb_prev_q & ~csb_s;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a csb fall opens a frame, and csb high closes it at any bit
  // position.
  // NOTE: every output of a combinational block gets its default first. A
  // path that leaves an output unassigned would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (csb_fall) begin
          state_d     = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (csb_s) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Edges that arrive in the cycle where csb has already risen are ignored.
  assign in_frame = (state_q == ACTIVE) & ~csb_s;

  // Latch the SPI mode while idle so that pin changes cannot disturb a frame
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cpol_q <= bus.cpol;
      cpha_q <= bus.cpha;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge decode
  // ---------------------------------------------------------------------------

  // A leading edge leaves the CPOL level. A trailing edge returns to it.
  assign lead_edge   = in_frame & (sclk_prev_q == cpol_q) & (sclk_s != cpol_q);
  assign trail_edge  = in_frame & (sclk_prev_q != cpol_q) & (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

  // bit_cnt_q is 0 on the first shift edge of a word. With CPHA=0 that is the
  // DATA_WIDTH-th trailing edge of the previous word.
  assign word_start  = (bit_cnt_q == '0);
  assign word_done   = sample_edge & (bit_cnt_q == LAST_BIT);
  assign hold_edge   = shift_edge & word_start & cpha_q & first_word_q;
  assign reload_edge = shift_edge & word_start & (~cpha_q | ~first_word_q);
  assign load        = frame_start | reload_edge;

  // Bit counter, plus a flag marking the first word of the frame
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bit_cnt_q    <= '0;
      first_word_q <= 1'b0;
    end else begin
      if (!in_frame) begin
        bit_cnt_q <= '0;
      end else if (sample_edge) begin
        bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
      end

      if (frame_start) begin
        first_word_q <= 1'b1;
      end else if (word_done) begin
        first_word_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------

  assign rx_next = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], din_s}
                             : {din_s, rx_shift_q[DATA_WIDTH-1:1]};
  assign rx_handshake = rx_valid_q & bus.rx_ready;

  // Assemble incoming bits. A partial word is dropped when the frame ends.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_shift_q <= '0;
    end else if (!in_frame) begin
      rx_shift_q <= '0;
    end else if (sample_edge) begin
      rx_shift_q <= rx_next;
    end
  end

  // Output register. A word completes into a free slot, or into a slot that
  // is being emptied in the same cycle. Otherwise the word is lost and an
  // overrun is flagged.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= word_done & rx_valid_q & ~bus.rx_ready;
      if (word_done && (!rx_valid_q || rx_handshake)) begin
        rx_data_q  <= rx_next;
        rx_valid_q <= 1'b1;
      end else if (rx_handshake) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------

  assign tx_handshake = bus.tx_valid & ~hold_full_q;
  assign load_word    = hold_full_q ? hold_q : '0;
  assign tx_shifted   = MSB_FIRST ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                                  : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};

  // Holding register. It fills on the handshake and empties when the shift
  // register takes it. Frame aborts leave it untouched.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_underrun_q <= load & ~hold_full_q;
      if (load) begin
        hold_full_q <= 1'b0;
      end
      if (tx_handshake) begin
        hold_q      <= bus.tx_data;
        hold_full_q <= 1'b1;
      end
    end
  end

  // Transmit shift register. It loads at frame start and at word boundaries,
  // and otherwise shifts on shift edges. Unsent bits are dropped when the
  // frame ends.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_shift_q <= '0;
    end else if (frame_start) begin
      tx_shift_q <= load_word;
    end else if (!in_frame) begin
      tx_shift_q <= '0;
    end else if (reload_edge) begin
      tx_shift_q <= load_word;
    end else if (shift_edge && !hold_edge) begin
      tx_shift_q <= tx_shifted;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.busy        = (state_q == ACTIVE);
  assign bus.dout        = (state_q == ACTIVE) & tx_shift_q[FIRST_BIT];

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed bench for spi_slave_sync.
// The bench uses two instances: a 16-bit MSB-first one, and an 8-bit
// LSB-first one with three synchroniser stages. They share sclk, din and the
// mode pins, and each has its own csb. The master model bit-bangs sclk at
// 1/16 of the clk rate and samples dout on the SPI sample edge of the
// current mode.
module tb_spi_slave_sync;

  localparam int HALF = 8;  // clk periods per sclk half period

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  logic sclk, din, cpol, cpha, csb16, csb8, sel8;
  logic dout_m;
  logic [63:0] miso;
  int vectors = 0;
  int miscompares = 0;
  int r0, o0, u0;

  spi_slave_sync_if #(.DATA_WIDTH(16)) bus16 ();
  spi_slave_sync_if #(.DATA_WIDTH(8))  bus8 ();

  assign bus16.sclk = sclk;
  assign bus16.din  = din;
  assign bus16.csb  = csb16;
  assign bus16.cpol = cpol;
  assign bus16.cpha = cpha;
  assign bus8.sclk  = sclk;
  assign bus8.din   = din;
  assign bus8.csb   = csb8;
  assign bus8.cpol  = cpol;
  assign bus8.cpha  = cpha;
  assign dout_m     = sel8 ? bus8.dout : bus16.dout;

  spi_slave_sync #(.DATA_WIDTH(16), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut16 (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus16.slave)
  );

  spi_slave_sync #(.DATA_WIDTH(8), .SYNC_STAGES(3), .MSB_FIRST(1'b0)) dut8 (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus8.slave)
  );

  // Pulse and rising-edge counters, sampled away from the active edge
  int rv16_rises = 0, ovr16 = 0, und16 = 0, rv8_rises = 0;
  logic rv16_prev = 1'b0, rv8_prev = 1'b0;
  always @(negedge clk) begin
    if (bus16.rx_valid && !rv16_prev) rv16_rises++;
    rv16_prev = bus16.rx_valid;
    if (bus8.rx_valid && !rv8_prev) rv8_rises++;
    rv8_prev = bus8.rx_valid;
    if (bus16.rx_overrun) ovr16++;
    if (bus16.tx_underrun) und16++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_mode(input logic p, input logic h);
    @(negedge clk);
    cpol = p;
    cpha = h;
    sclk = p;
    din  = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic push(input logic [63:0] w);
    @(negedge clk);
    if (sel8) begin
      bus8.tx_data  = w[7:0];
      bus8.tx_valid = 1'b1;
    end else begin
      bus16.tx_data  = w[15:0];
      bus16.tx_valid = 1'b1;
    end
    @(negedge clk);
    bus8.tx_valid  = 1'b0;
    bus16.tx_valid = 1'b0;
  endtask

  task automatic drain;
    @(negedge clk);
    if (sel8) bus8.rx_ready = 1'b1;
    else      bus16.rx_ready = 1'b1;
    @(negedge clk);
    bus8.rx_ready  = 1'b0;
    bus16.rx_ready = 1'b0;
  endtask

  task automatic frame_begin;
    @(negedge clk);
    if (sel8) csb8 = 1'b0;
    else      csb16 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame_end;
    repeat (10) @(negedge clk);
    csb8  = 1'b1;
    csb16 = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // One word from the master's side. The master drives on its shift edge and
  // samples dout on its sample edge.
  task automatic spi_word(input logic [63:0] mosi, input int nbits, input bit lsb_first,
                          output logic [63:0] rd);
    rd = '0;
    for (int k = 0; k < nbits; k++) begin
      int idx;
      idx = lsb_first ? k : nbits - 1 - k;
      if (!cpha) begin
        din = mosi[idx];
        repeat (HALF) @(negedge clk);
        rd[idx] = dout_m;
        sclk = ~cpol;
        repeat (HALF) @(negedge clk);
        sclk = cpol;
      end else begin
        repeat (HALF) @(negedge clk);
        sclk = ~cpol;
        din  = mosi[idx];
        repeat (HALF) @(negedge clk);
        rd[idx] = dout_m;
        sclk = cpol;
      end
    end
  endtask

  initial begin
    sclk = 1'b0; din = 1'b0; cpol = 1'b0; cpha = 1'b0;
    csb16 = 1'b1; csb8 = 1'b1; sel8 = 1'b0;
    bus16.tx_data = '0; bus16.tx_valid = 1'b0; bus16.rx_ready = 1'b0;
    bus8.tx_data  = '0; bus8.tx_valid  = 1'b0; bus8.rx_ready  = 1'b0;

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_tx_ready",    bus16.tx_ready, 1);
    check("rst_rx_valid",    bus16.rx_valid, 0);
    check("rst_busy",        bus16.busy, 0);
    check("rst_dout",        bus16.dout, 0);
    check("rst_rx_data",     bus16.rx_data, 0);
    check("rst_rx_overrun",  bus16.rx_overrun, 0);
    check("rst_tx_underrun", bus16.tx_underrun, 0);
    check("rst8_tx_ready",   bus8.tx_ready, 1);
    resetb = 1'b1;
    repeat (6) @(negedge clk);

    // Mode 0: tx 0xA55A, master sends 0x1234
    set_mode(1'b0, 1'b0);
    push(64'hA55A);
    check("m0_hold_full", bus16.tx_ready, 0);
    r0 = rv16_rises;
    frame_begin;
    check("m0_busy", bus16.busy, 1);
    spi_word(64'h1234, 16, 1'b0, miso);
    frame_end;
    check("m0_miso", miso, 64'hA55A);
    check("m0_rx_data", bus16.rx_data, 64'h1234);
    check("m0_rx_valid_once", 64'(rv16_rises - r0), 1);
    check("m0_busy_idle", bus16.busy, 0);
    drain;
    check("m0_rx_valid_clr", bus16.rx_valid, 0);

    // Modes 1..3: tx 0x8001, master sends 0x7FFE
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      push(64'h8001);
      r0 = rv16_rises;
      frame_begin;
      spi_word(64'h7FFE, 16, 1'b0, miso);
      frame_end;
      check($sformatf("mode%0d_miso", m), miso, 64'h8001);
      check($sformatf("mode%0d_rx_data", m), bus16.rx_data, 64'h7FFE);
      check($sformatf("mode%0d_rx_valid_once", m), 64'(rv16_rises - r0), 1);
      drain;
    end

    // Two words, rx_ready low: first kept, one overrun
    set_mode(1'b0, 1'b0);
    r0 = rv16_rises; o0 = ovr16;
    frame_begin;
    spi_word(64'hBEEF, 16, 1'b0, miso);
    spi_word(64'hCAFE, 16, 1'b0, miso);
    frame_end;
    check("ovr_rx_data_first", bus16.rx_data, 64'hBEEF);
    check("ovr_pulse_once", 64'(ovr16 - o0), 1);
    check("ovr_rx_valid_once", 64'(rv16_rises - r0), 1);
    drain;

    // Two words, rx_ready high: both delivered, no overrun
    bus16.rx_ready = 1'b1;
    r0 = rv16_rises; o0 = ovr16;
    frame_begin;
    spi_word(64'h0101, 16, 1'b0, miso);
    spi_word(64'h0202, 16, 1'b0, miso);
    frame_end;
    check("rdy_no_overrun", 64'(ovr16 - o0), 0);
    check("rdy_rx_data_second", bus16.rx_data, 64'h0202);
    check("rdy_rx_valid_twice", 64'(rv16_rises - r0), 2);
    check("rdy_rx_valid_clr", bus16.rx_valid, 0);
    bus16.rx_ready = 1'b0;

    // Underrun: nothing queued, mode 1 so only the frame-start load happens
    set_mode(1'b0, 1'b1);
    check("ur_hold_empty", bus16.tx_ready, 1);
    u0 = und16;
    frame_begin;
    spi_word(64'h0F0F, 16, 1'b0, miso);
    frame_end;
    check("ur_dout_zero", miso, 0);
    check("ur_pulse_once", 64'(und16 - u0), 1);
    drain;

    // Partial word of 7 bits, then a full 0x00FF
    set_mode(1'b0, 1'b0);
    r0 = rv16_rises;
    frame_begin;
    spi_word(64'h55, 7, 1'b0, miso);
    frame_end;
    check("partial_no_rx_valid", 64'(rv16_rises - r0), 0);
    frame_begin;
    spi_word(64'h00FF, 16, 1'b0, miso);
    frame_end;
    check("partial_then_rx_data", bus16.rx_data, 64'h00FF);
    check("partial_then_rx_valid", 64'(rv16_rises - r0), 1);
    drain;

    // Aborted frame keeps the holding register
    set_mode(1'b0, 1'b1);
    push(64'h1357);
    frame_begin;
    push(64'h2468);
    spi_word(64'h0, 4, 1'b0, miso);
    frame_end;
    check("abort_hold_kept", bus16.tx_ready, 0);
    frame_begin;
    spi_word(64'h0, 16, 1'b0, miso);
    frame_end;
    check("abort_next_word", miso, 64'h2468);
    drain;

    // Reset in the middle of a frame, released with csb still low
    set_mode(1'b0, 1'b0);
    frame_begin;
    spi_word(64'hFFFF, 5, 1'b0, miso);
    @(negedge clk);
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", bus16.busy, 0);
    check("midrst_tx_ready", bus16.tx_ready, 1);
    check("midrst_rx_data", bus16.rx_data, 0);
    resetb = 1'b1;
    repeat (6) @(negedge clk);
    spi_word(64'hFFFF, 8, 1'b0, miso);
    check("postrst_idle_busy", bus16.busy, 0);
    check("postrst_idle_dout", dout_m, 0);
    check("postrst_no_rx_valid", bus16.rx_valid, 0);
    frame_end;
    push(64'h0F0F);
    frame_begin;
    spi_word(64'h3C3C, 16, 1'b0, miso);
    frame_end;
    check("postrst_miso", miso, 64'h0F0F);
    check("postrst_rx_data", bus16.rx_data, 64'h3C3C);
    drain;

    // 8-bit LSB-first instance
    sel8 = 1'b1;
    set_mode(1'b0, 1'b0);
    push(64'h01);
    r0 = rv8_rises;
    frame_begin;
    check("lsb_first_dout_bit", dout_m, 1);
    spi_word(64'h80, 8, 1'b1, miso);
    frame_end;
    check("lsb_miso", miso, 64'h01);
    check("lsb_rx_data", bus8.rx_data, 64'h80);
    check("lsb_rx_valid_once", 64'(rv8_rises - r0), 1);
    drain;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
